pattern_matcher: RTL and testbench
==================================

Name: pattern_matcher

Overview:
Parametrised brute-force string matcher that scans a text memory for every occurrence of a pattern held in a pattern memory. It is the successor to the fixed 4-character, fixed-length text search engine. Pattern length, text length and start offset are set at run time, and overlapping or non-overlapping counting is selectable. It reports a saturating match count, the first match position and a per-match pulse. It drives external synchronous-read ROMs for text and pattern and sits between the top-level start control and the 7-segment/LED result display.

Parameters:
DATA_W, 8, character width
PAT_AW, 3, pattern address width; maximum pattern length 2**PAT_AW
TEXT_AW, 14, text address width
CNT_W, 8, match counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  begin a search; sampled only in IDLE
overlap  in  1  1 = advance alignment by 1 after a match; 0 = advance by pat_len; sampled at start
pat_len  in  PAT_AW+1  pattern length, 0..2**PAT_AW; sampled at start
text_len  in  TEXT_AW+1  number of valid text characters; sampled at start
text_base  in  TEXT_AW  first alignment to test; sampled at start
text_addr  out  TEXT_AW  text ROM address
text_data  in  DATA_W  text ROM data, valid 1 cycle after address
pat_addr  out  PAT_AW  pattern ROM address
pat_data  in  DATA_W  pattern ROM data, valid 1 cycle after address
busy  out  1  search in progress
done  out  1  1-cycle pulse at end of search
match_pulse  out  1  1-cycle pulse per recorded match
match_count  out  CNT_W  matches found, saturating
found  out  1  at least one match found this search
first_pos  out  TEXT_AW  alignment of the first match

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0: busy, done, match_pulse, match_count, found, first_pos, text_addr, pat_addr.
- Internal registers: alignment i (TEXT_AW+1 bits), char index j (PAT_AW+1 bits), latched overlap, pat_len, text_len.
- text_addr = i+j truncated to TEXT_AW bits. pat_addr = j truncated to PAT_AW bits. Both are registered.
- States:
  - IDLE: start=1 latches the configuration, sets i=text_base and j=0, and clears match_count, found and first_pos.
    - If pat_len==0 or text_base+pat_len > text_len (computed at TEXT_AW+2 bits): go to DONE.
    - Otherwise: go to FETCH.
  - FETCH: addresses stable; wait 1 cycle for ROM latency; go to CMP.
  - CMP: compare text_data with pat_data.
    - Mismatch: j=0, i=i+1.
    - Match with j<pat_len-1: j=j+1, go to FETCH.
    - Match with j==pat_len-1: record a match. match_pulse=1. match_count increments and holds at 2**CNT_W-1. If found==0, first_pos=i and found=1. Then j=0 and i=i+1 (overlap=1) or i=i+pat_len (overlap=0).
    - After any alignment advance: go to DONE if the new i+pat_len > text_len, else go to FETCH.
  - DONE: done=1 for exactly 1 cycle, busy=0, then go to IDLE.
- busy=1 in FETCH and CMP only.
- Each compared character costs 2 cycles.
- start outside IDLE is ignored. start held high in IDLE while entering DONE does not relaunch until IDLE is re-entered.
- Results (match_count, found, first_pos) hold their values until the next accepted start or reset.
- Reset mid-search aborts immediately to IDLE and clears all outputs.
- text_len beyond 2**TEXT_AW is caller error; address wraps modulo 2**TEXT_AW.

Test Plan:
- Reset mid-search (rst=0 during CMP) -> busy=0, match_count=0 and found=0 asynchronously. A new start then runs a clean search.
- text "AB", pat "AB", pat_len=2, text_len=2, start at cycle 0 -> match_pulse at cycle 4, done at cycle 5, match_count=1, first_pos=0.
- text "AAAA", pat "AA", text_len=4: overlap=1 -> match_count=3, first_pos=0. overlap=0 -> match_count=2.
- text "ABCABD", pat "ABD", text_len=6, text_base=0 -> match_count=1, found=1, first_pos=3. Same search with text_base=4 -> done 1 cycle after start, match_count=0, found=0.
- pat_len=0 -> done at cycle 1, busy never 1, match_count=0. start pulsed during busy -> ignored, results unchanged.
- CNT_W=2, text of 10 'A', pat "A", overlap=1 -> match_count saturates at 3, match_pulse still fires 10 times, first_pos=0.

Source files
------------

// File: rtl/pattern_matcher.sv
// Brute-force string matcher: scans a text ROM for every alignment where the pattern ROM matches,
// with run-time pattern length, text length, start offset and overlap mode.
module pattern_matcher #(
    parameter int DATA_W  = 8,
    parameter int PAT_AW  = 3,
    parameter int TEXT_AW = 14,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               overlap,
    input  logic [PAT_AW:0]    pat_len,
    input  logic [TEXT_AW:0]   text_len,
    input  logic [TEXT_AW-1:0] text_base,
    output logic [TEXT_AW-1:0] text_addr,
    input  logic [DATA_W-1:0]  text_data,
    output logic [PAT_AW-1:0]  pat_addr,
    input  logic [DATA_W-1:0]  pat_data,
    output logic               busy,
    output logic               done,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               found,
    output logic [TEXT_AW-1:0] first_pos
);

    localparam int IW = TEXT_AW + 1;
    localparam int EW = TEXT_AW + 2;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CMP, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [TEXT_AW:0]     i_q, i_d;
    logic [PAT_AW:0]      j_q, j_d;
    logic                 overlap_q, overlap_d;
    logic [PAT_AW:0]      pat_len_q, pat_len_d;
    logic [TEXT_AW:0]     text_len_q, text_len_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 found_q, found_d;
    logic [TEXT_AW-1:0]   first_q, first_d;
    logic [TEXT_AW-1:0]   text_addr_q;
    logic [PAT_AW-1:0]    pat_addr_q;
    logic [TEXT_AW:0]     addr_sum;
    logic                 hit;
    logic                 advance;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        overlap_d  = overlap_q;
        pat_len_d  = pat_len_q;
        text_len_d = text_len_q;
        count_d    = count_q;
        found_d    = found_q;
        first_d    = first_q;
        hit        = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    overlap_d  = overlap;
                    pat_len_d  = pat_len;
                    text_len_d = text_len;
                    i_d        = IW'(text_base);
                    j_d        = '0;
                    count_d    = '0;
                    found_d    = 1'b0;
                    first_d    = '0;
                    if (pat_len == '0 || EW'(text_base) + EW'(pat_len) > EW'(text_len))
                        state_d = S_DONE;
                    else
                        state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_CMP;
            S_CMP: begin
                if (text_data != pat_data) begin
                    j_d     = '0;
                    i_d     = i_q + IW'(1);
                    advance = 1'b1;
                end else if (j_q != pat_len_q - 1'b1) begin
                    j_d     = j_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    hit     = 1'b1;
                    count_d = (&count_q) ? count_q : count_q + 1'b1;
                    if (!found_q) begin
                        found_d = 1'b1;
                        first_d = TEXT_AW'(i_q);
                    end
                    j_d     = '0;
                    i_d     = overlap_q ? i_q + IW'(1) : i_q + IW'(pat_len_q);
                    advance = 1'b1;
                end
                // The next alignment must leave room for the whole pattern inside the text.
                if (advance)
                    state_d = (EW'(i_d) + EW'(pat_len_q) > EW'(text_len_q)) ? S_DONE : S_FETCH;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ROM addresses are registered from the next-state alignment so they are stable in FETCH.
    assign addr_sum = i_d + IW'(j_d);

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            overlap_q   <= 1'b0;
            pat_len_q   <= '0;
            text_len_q  <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            first_q     <= '0;
            text_addr_q <= '0;
            pat_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            overlap_q   <= overlap_d;
            pat_len_q   <= pat_len_d;
            text_len_q  <= text_len_d;
            count_q     <= count_d;
            found_q     <= found_d;
            first_q     <= first_d;
            text_addr_q <= TEXT_AW'(addr_sum);
            pat_addr_q  <= PAT_AW'(j_d);
        end
    end

    assign text_addr   = text_addr_q;
    assign pat_addr    = pat_addr_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_CMP);
    assign done        = (state_q == S_DONE);
    assign match_pulse = hit;
    assign match_count = count_q;
    assign found       = found_q;
    assign first_pos   = first_q;

endmodule

// File: tb/tb_pattern_matcher.sv
// Scoreboard bench for pattern_matcher: a default instance and a CNT_W=2 instance run in lockstep
// against a brute-force search model; a monitor checks pulses and results as the DUTs present them.
module tb_pattern_matcher;

    localparam int DATA_W  = 8;
    localparam int PAT_AW  = 3;
    localparam int TEXT_AW = 14;
    localparam int CNT_W   = 8;
    localparam int CNT_WS  = 2;
    localparam int TEXT_N  = 1 << TEXT_AW;
    localparam int PAT_N   = 1 << PAT_AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               start = 1'b0;
    logic               overlap = 1'b0;
    logic [PAT_AW:0]    pat_len = '0;
    logic [TEXT_AW:0]   text_len = '0;
    logic [TEXT_AW-1:0] text_base = '0;

    logic [TEXT_AW-1:0] a_text_addr, b_text_addr, a_first_pos, b_first_pos;
    logic [PAT_AW-1:0]  a_pat_addr, b_pat_addr;
    logic [DATA_W-1:0]  a_text_data, b_text_data, a_pat_data, b_pat_data;
    logic               a_busy, a_done, a_match_pulse, a_found;
    logic               b_busy, b_done, b_match_pulse, b_found;
    logic [CNT_W-1:0]   a_count;
    logic [CNT_WS-1:0]  b_count;

    logic [DATA_W-1:0] text_mem [TEXT_N];
    logic [DATA_W-1:0] pat_mem  [PAT_N];

    always @(posedge clk) begin
        a_text_data <= text_mem[a_text_addr];
        a_pat_data  <= pat_mem[a_pat_addr];
        b_text_data <= text_mem[b_text_addr];
        b_pat_data  <= pat_mem[b_pat_addr];
    end

    pattern_matcher #(.DATA_W(DATA_W), .PAT_AW(PAT_AW), .TEXT_AW(TEXT_AW), .CNT_W(CNT_W)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .overlap(overlap), .pat_len(pat_len),
        .text_len(text_len), .text_base(text_base), .text_addr(a_text_addr), .text_data(a_text_data),
        .pat_addr(a_pat_addr), .pat_data(a_pat_data), .busy(a_busy), .done(a_done),
        .match_pulse(a_match_pulse), .match_count(a_count), .found(a_found), .first_pos(a_first_pos)
    );

    pattern_matcher #(.DATA_W(DATA_W), .PAT_AW(PAT_AW), .TEXT_AW(TEXT_AW), .CNT_W(CNT_WS)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .overlap(overlap), .pat_len(pat_len),
        .text_len(text_len), .text_base(text_base), .text_addr(b_text_addr), .text_data(b_text_data),
        .pat_addr(b_pat_addr), .pat_data(b_pat_data), .busy(b_busy), .done(b_done),
        .match_pulse(b_match_pulse), .match_count(b_count), .found(b_found), .first_pos(b_first_pos)
    );

    typedef struct {
        int count;
        bit found;
        int first_pos;
        int done_cyc;
        int busy_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   pos_q[$];
    exp_t last_exp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Monitor: consumes the scoreboard whenever the DUTs present a pulse or a done.
    int busy_cnt = 0;
    int a_pulses = 0;
    int b_pulses = 0;
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
            a_pulses = 0;
            b_pulses = 0;
        end else begin
            if (a_busy) busy_cnt++;
            if (b_match_pulse) b_pulses++;
            if (a_match_pulse) begin
                a_pulses++;
                if (pos_q.size() == 0) check("unexpected_pulse", 1, 0);
                else check("pulse_addr", a_text_addr, pos_q.pop_front());
            end
            if (a_done || b_done) begin
                exp_t e;
                check("done_pair", {a_done, b_done}, 2'b11);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_cycles", busy_cnt, e.busy_cycles);
                    check("busy_at_done", a_busy, 0);
                    check("count_a", a_count, sat(e.count, CNT_W));
                    check("count_b", b_count, sat(e.count, CNT_WS));
                    check("found_a", a_found, e.found);
                    check("found_b", b_found, e.found);
                    check("first_a", a_first_pos, e.first_pos);
                    check("first_b", b_first_pos, e.first_pos);
                    check("pulses_a", a_pulses, e.count);
                    check("pulses_b", b_pulses, e.count);
                    check("pulses_left", pos_q.size(), 0);
                end
                busy_cnt = 0;
                a_pulses = 0;
                b_pulses = 0;
            end
        end
    end

    task automatic load_text(input string s, input int at);
        for (int k = 0; k < s.len(); k++) text_mem[(at + k) % TEXT_N] = s[k];
    endtask

    task automatic load_pat(input string s);
        for (int k = 0; k < s.len() && k < PAT_N; k++) pat_mem[k] = s[k];
    endtask

    // Reference search from the matching rules, then issue start for exactly one cycle.
    task automatic launch(input int base, input int tlen, input int plen, input bit ovl);
        exp_t e;
        int   i = base;
        int   ncmp = 0;
        e.count = 0; e.found = 0; e.first_pos = 0;
        if (plen != 0 && base + plen <= tlen) begin
            while (i + plen <= tlen) begin
                bit m = 1;
                for (int j = 0; j < plen; j++) begin
                    ncmp++;
                    if (text_mem[(i + j) % TEXT_N] != pat_mem[j]) begin
                        m = 0;
                        break;
                    end
                end
                if (m) begin
                    if (!e.found) begin
                        e.found = 1;
                        e.first_pos = i % TEXT_N;
                    end
                    e.count++;
                    pos_q.push_back((i + plen - 1) % TEXT_N);
                    i += ovl ? 1 : plen;
                end else begin
                    i++;
                end
            end
        end
        e.busy_cycles = 2 * ncmp;
        e.done_cyc    = cyc + 1 + 2 * ncmp;
        exp_q.push_back(e);
        last_exp  = e;
        text_base = TEXT_AW'(base);
        text_len  = (TEXT_AW + 1)'(tlen);
        pat_len   = (PAT_AW + 1)'(plen);
        overlap   = ovl;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        check("done_seen", seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_hold();
        repeat (3) @(posedge clk);
        #1;
        check("hold_count", a_count, sat(last_exp.count, CNT_W));
        check("hold_found", a_found, last_exp.found);
        check("hold_first", a_first_pos, last_exp.first_pos);
    endtask

    task automatic search(input int base, input int tlen, input int plen, input bit ovl);
        launch(base, tlen, plen, ovl);
        wait_done(2 * TEXT_N);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < TEXT_N; k++) text_mem[k] = 8'h00;
        for (int k = 0; k < PAT_N; k++) pat_mem[k] = 8'h00;

        #2;
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_pulse", a_match_pulse, 0);
        check("rst_count", a_count, 0);
        check("rst_found", a_found, 0);
        check("rst_first", a_first_pos, 0);
        check("rst_taddr", a_text_addr, 0);
        check("rst_paddr", a_pat_addr, 0);
        #20 rst = 1'b1;
        @(posedge clk); #1;

        // Two-character exact match: pulse at start+4, done at start+5.
        load_text("AB", 0); load_pat("AB");
        search(0, 2, 2, 1'b1);
        check_hold();

        // Overlapping vs non-overlapping counting.
        load_text("AAAA", 0); load_pat("AA");
        search(0, 4, 2, 1'b1);
        search(0, 4, 2, 1'b0);

        // Match only at the tail; then a base that leaves no room for the pattern.
        load_text("ABCABD", 0); load_pat("ABD");
        search(0, 6, 3, 1'b1);
        search(4, 6, 3, 1'b1);

        // Empty pattern finishes immediately without going busy.
        search(0, 6, 0, 1'b1);

        // start pulses while busy are ignored.
        launch(0, 6, 3, 1'b1);
        pat_len = '0; text_base = TEXT_AW'(5); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        check_hold();

        // Ten single-character matches saturate the narrow counter at 3.
        load_text("AAAAAAAAAA", 0); load_pat("A");
        search(0, 10, 1, 1'b1);

        // Reset during CMP after one match has been recorded.
        load_pat("AA");
        launch(0, 10, 2, 1'b1);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", a_busy, 0);
        check("midrst_count", a_count, 0);
        check("midrst_found", a_found, 0);
        check("midrst_done", a_done, 0);
        exp_q.delete();
        pos_q.delete();
        #10 rst = 1'b1;
        @(posedge clk); #1;
        load_text("AB", 0); load_pat("AB");
        search(0, 2, 2, 1'b1);

        // Randomised searches over a small alphabet so matches are frequent.
        for (int t = 0; t < 40; t++) begin
            int plen = $urandom_range(0, PAT_N);
            int tlen = $urandom_range(0, 64);
            int base = $urandom_range(0, 20);
            for (int k = 0; k < 64; k++) text_mem[k] = ($urandom_range(0, 3) == 0) ? "B" : "A";
            for (int k = 0; k < PAT_N; k++) pat_mem[k] = ($urandom_range(0, 4) == 0) ? "B" : "A";
            search(base, tlen, plen, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
